// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, instruction field positions and the ID/EX payload.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned IMM_W  = 16;

  localparam int unsigned OP_LSB = 26;
  localparam int unsigned RS_LSB = 21;
  localparam int unsigned RT_LSB = 16;
  localparam int unsigned RD_LSB = 11;

  localparam logic [OP_W-1:0] BUBBLE_OP = 6'h3F;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 6'h00, OP_ADDI = 6'h01, OP_SUB  = 6'h02, OP_SUBI = 6'h03,
    OP_MUL  = 6'h04, OP_MULI = 6'h05, OP_OR   = 6'h06, OP_ORI  = 6'h07,
    OP_AND  = 6'h08, OP_ANDI = 6'h09, OP_XOR  = 6'h0A, OP_XORI = 6'h0B,
    OP_LDW  = 6'h0C, OP_STW  = 6'h0D, OP_BZ   = 6'h0E, OP_BEQ  = 6'h0F,
    OP_JR   = 6'h10, OP_HALT = 6'h11
  } op_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [XLEN-1:0]   rs;
    logic [XLEN-1:0]   rt;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc4;
    logic              mem_read;
    logic              mem_to_reg;
    logic              mem_write;
    logic              reg_write;
    logic [REG_AW-1:0] rd;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '{
    op: BUBBLE_OP, rs: '0, rt: '0, imm: '0, pc4: '0,
    mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, reg_write: 1'b0, rd: '0
  };

  function automatic logic [XLEN-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file: two async read ports, one sync write port, R0 hardwired to zero.
// ID_WB_BYPASS_EN: a same-cycle writeback to a read address is forwarded to the read port.
module id_regfile import pipe_pkg::*; #(
  parameter int unsigned NREG = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] i_ra_a,
  input  logic [REG_AW-1:0] i_ra_b,
  output logic [XLEN-1:0]   o_rd_a,
  output logic [XLEN-1:0]   o_rd_b,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wa,
  input  logic [XLEN-1:0]   i_wd
);

  logic [XLEN-1:0] r_mem [NREG];
  logic            w_wr;

  assign w_wr = i_we && (i_wa != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem <= '{default: '0};
    end else if (w_wr) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  always_comb begin
    o_rd_a = (i_ra_a == '0) ? '0 : r_mem[i_ra_a];
    o_rd_b = (i_ra_b == '0) ? '0 : r_mem[i_ra_b];
`ifdef ID_WB_BYPASS_EN
    if (w_wr && (i_wa == i_ra_a)) o_rd_a = i_wd;
    if (w_wr && (i_wa == i_ra_b)) o_rd_b = i_wd;
`endif
  end

endmodule

// File: rtl/id_stage.sv
// Instruction decode: field split, register read, load-use stall, HALT tracking, ID/EX register.
// Optional macro ID_WB_BYPASS_EN (in id_regfile) enables write-before-read forwarding.
module id_stage #(
  parameter int unsigned NREG      = 32,
  parameter logic [5:0]  BUBBLE_OP = 6'h3F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_2_id,
  input  logic        instr_valid_2_id,
  input  logic [31:0] pc4_2_id,
  input  logic        flush_2_id,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic [5:0]  op,
  output logic [31:0] rs,
  output logic [31:0] rt,
  output logic [31:0] i_data_2_ex,
  output logic [31:0] pc4_out_2_ex,
  output logic        mem_read_2_ex,
  output logic        mem_to_reg_2_ex,
  output logic        mem_write_2_ex,
  output logic        reg_write_2_ex,
  output logic [4:0]  rd_add_value_2_ex,
  output logic        stall_2_if,
  output logic        halted
);
  import pipe_pkg::*;

  id_ex_t            r_idex;
  logic              r_halted;
  id_ex_t            w_bubble;
  id_ex_t            w_dec;
  id_ex_t            w_idex_nxt;
  logic              w_halted_nxt;
  logic [OP_W-1:0]   w_op;
  logic [REG_AW-1:0] w_rs_a;
  logic [REG_AW-1:0] w_rt_a;
  logic [REG_AW-1:0] w_rd_a;
  logic [XLEN-1:0]   w_rs_d;
  logic [XLEN-1:0]   w_rt_d;
  logic              w_use_rs;
  logic              w_use_rt;
  logic              w_legal;
  logic              w_is_halt;
  logic              w_hazard;

  assign w_op   = instr_2_id[OP_LSB +: OP_W];
  assign w_rs_a = instr_2_id[RS_LSB +: REG_AW];
  assign w_rt_a = instr_2_id[RT_LSB +: REG_AW];
  assign w_rd_a = instr_2_id[RD_LSB +: REG_AW];

  id_regfile #(.NREG(NREG)) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .i_ra_a (w_rs_a),
    .i_ra_b (w_rt_a),
    .o_rd_a (w_rs_d),
    .o_rd_b (w_rt_d),
    .i_we   (wb_en),
    .i_wa   (wb_addr),
    .i_wd   (wb_data)
  );

  always_comb begin
    w_bubble    = ID_EX_BUBBLE;
    w_bubble.op = BUBBLE_OP;
  end

  // Opcode decode: controls, destination and which source fields are really read.
  always_comb begin
    w_dec            = ID_EX_BUBBLE;
    w_dec.op         = w_op;
    w_dec.rs         = w_rs_d;
    w_dec.rt         = w_rt_d;
    w_dec.imm        = sext_imm(instr_2_id[IMM_W-1:0]);
    w_dec.pc4        = pc4_2_id;
    w_use_rs         = 1'b0;
    w_use_rt         = 1'b0;
    w_legal          = 1'b1;
    w_is_halt        = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB, OP_MUL, OP_OR, OP_AND, OP_XOR: begin
        w_use_rs        = 1'b1;
        w_use_rt        = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.rd        = w_rd_a;
      end
      OP_ADDI, OP_SUBI, OP_MULI, OP_ORI, OP_ANDI, OP_XORI: begin
        w_use_rs        = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.rd        = w_rt_a;
      end
      OP_LDW: begin
        w_use_rs         = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.rd         = w_rt_a;
      end
      OP_STW, OP_BEQ: begin
        w_use_rs        = 1'b1;
        w_use_rt        = 1'b1;
        w_dec.mem_write = (w_op == OP_STW);
      end
      OP_BZ, OP_JR: w_use_rs = 1'b1;
      OP_HALT: begin
        w_legal   = 1'b0;
        w_is_halt = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Load-use: the load in ID/EX targets a register this instruction actually reads.
  assign w_hazard = instr_valid_2_id && r_idex.mem_read && (r_idex.rd != '0) &&
                    ((w_use_rs && (w_rs_a == r_idex.rd)) || (w_use_rt && (w_rt_a == r_idex.rd)));

  assign stall_2_if = !reset && !flush_2_id && (r_halted || w_hazard);

  always_comb begin
    w_idex_nxt   = w_bubble;
    w_halted_nxt = r_halted;
    if (flush_2_id || r_halted || w_hazard || !instr_valid_2_id) begin
      w_idex_nxt = w_bubble;
    end else if (w_is_halt) begin
      w_halted_nxt = 1'b1;
    end else if (w_legal) begin
      w_idex_nxt = w_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idex   <= w_bubble;
      r_halted <= 1'b0;
    end else begin
      r_idex   <= w_idex_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  assign op                = r_idex.op;
  assign rs                = r_idex.rs;
  assign rt                = r_idex.rt;
  assign i_data_2_ex       = r_idex.imm;
  assign pc4_out_2_ex      = r_idex.pc4;
  assign mem_read_2_ex     = r_idex.mem_read;
  assign mem_to_reg_2_ex   = r_idex.mem_to_reg;
  assign mem_write_2_ex    = r_idex.mem_write;
  assign reg_write_2_ex    = r_idex.reg_write;
  assign rd_add_value_2_ex = r_idex.rd;
  assign halted            = r_halted;

endmodule

// File: tb/tb_id_stage.sv
// Directed plus random bench for id_stage against an opcode-table reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_2_id;
  logic        instr_valid_2_id;
  logic [31:0] pc4_2_id;
  logic        flush_2_id;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [5:0]  op;
  logic [31:0] rs, rt, i_data_2_ex, pc4_out_2_ex;
  logic        mem_read_2_ex, mem_to_reg_2_ex, mem_write_2_ex, reg_write_2_ex;
  logic [4:0]  rd_add_value_2_ex;
  logic        stall_2_if, halted;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .instr_2_id(instr_2_id), .instr_valid_2_id(instr_valid_2_id),
    .pc4_2_id(pc4_2_id), .flush_2_id(flush_2_id), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .op(op), .rs(rs), .rt(rt), .i_data_2_ex(i_data_2_ex),
    .pc4_out_2_ex(pc4_out_2_ex), .mem_read_2_ex(mem_read_2_ex), .mem_to_reg_2_ex(mem_to_reg_2_ex),
    .mem_write_2_ex(mem_write_2_ex), .reg_write_2_ex(reg_write_2_ex),
    .rd_add_value_2_ex(rd_add_value_2_ex), .stall_2_if(stall_2_if), .halted(halted)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] pc = 32'h0;

  // Reference model state: architectural registers, halt flag, expected ID/EX contents.
  logic [31:0] m_regs [32];
  logic        m_halted;
  logic [5:0]  e_op;
  logic [31:0] e_rs, e_rt, e_imm, e_pc4;
  logic        e_mr, e_m2r, e_mw, e_rw;
  logic [4:0]  e_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rins(input logic [5:0] o, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
    return {o, a, b, d, 11'd0};
  endfunction

  function automatic logic [31:0] iins(input logic [5:0] o, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] imm);
    return {o, a, b, imm};
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_regs[a];
  endfunction

  task automatic set_bubble();
    e_op = 6'h3F; e_rs = 0; e_rt = 0; e_imm = 0; e_pc4 = 0;
    e_mr = 0; e_m2r = 0; e_mw = 0; e_rw = 0; e_rd = 0;
  endtask

  task automatic check_outputs();
    chk("op", 32'(op), 32'(e_op));
    chk("rs", rs, e_rs);
    chk("rt", rt, e_rt);
    chk("imm", i_data_2_ex, e_imm);
    chk("pc4", pc4_out_2_ex, e_pc4);
    chk("mem_read", 32'(mem_read_2_ex), 32'(e_mr));
    chk("mem_to_reg", 32'(mem_to_reg_2_ex), 32'(e_m2r));
    chk("mem_write", 32'(mem_write_2_ex), 32'(e_mw));
    chk("reg_write", 32'(reg_write_2_ex), 32'(e_rw));
    chk("rd", 32'(rd_add_value_2_ex), 32'(e_rd));
    chk("halted", 32'(halted), 32'(m_halted));
  endtask

  // One clock: drive inputs, check the combinational stall, advance the model, check ID/EX.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic rst);
    logic [5:0] o;
    logic [4:0] a, b, d;
    logic arith, odd, ur, ut, haz, exp_stall;
    @(negedge clk);
    pc = pc + 32'd4;
    instr_2_id = ins; instr_valid_2_id = v; flush_2_id = fl; pc4_2_id = pc;
    wb_en = we; wb_addr = wa; wb_data = wd; reset = rst;
    o = ins[31:26]; a = ins[25:21]; b = ins[20:16]; d = ins[15:11];
    arith = (o <= 6'h0B);
    odd   = o[0];
    ur    = (o <= 6'h10);
    ut    = (arith && !odd) || o == 6'h0D || o == 6'h0F;
    haz   = v && e_mr && e_rd != 0 && ((ur && a == e_rd) || (ut && b == e_rd));
    exp_stall = !rst && !fl && (m_halted || haz);
    #1;
    chk("stall", 32'(stall_2_if), 32'(exp_stall));
    if (rst) begin
      set_bubble();
      m_halted = 1'b0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      if (fl || m_halted || haz || !v || o > 6'h11) begin
        set_bubble();
      end else if (o == 6'h11) begin
        set_bubble();
        m_halted = 1'b1;
      end else begin
        e_op = o; e_rs = mread(a, we, wa, wd); e_rt = mread(b, we, wa, wd);
        e_imm = {{16{ins[15]}}, ins[15:0]}; e_pc4 = pc;
        e_mr = (o == 6'h0C); e_m2r = (o == 6'h0C); e_mw = (o == 6'h0D);
        e_rw = arith || o == 6'h0C;
        e_rd = !arith ? ((o == 6'h0C) ? b : 5'd0) : (odd ? b : d);
      end
      if (we && wa != 0) m_regs[wa] = wd;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1; instr_2_id = 0; instr_valid_2_id = 0; pc4_2_id = 0;
    flush_2_id = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    set_bubble();
    m_halted = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

    step(32'hFFFF_FFFF, 1, 0, 1, 5'd9, 32'hDEAD, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_op", 32'(op), 32'h3F);

    step(32'h0401FFFB, 1, 0, 0, 0, 0, 0);
    chk("addi_op", 32'(op), 32'h01);
    chk("addi_imm", i_data_2_ex, 32'hFFFFFFFB);
    chk("addi_rd", 32'(rd_add_value_2_ex), 32'd1);

    step(0, 0, 0, 1, 5'd2, 32'd7, 0);
    step(0, 0, 0, 1, 5'd3, 32'd9, 0);
    step(rins(6'h02, 5'd2, 5'd3, 5'd4), 1, 0, 0, 0, 0, 0);
    chk("sub_rs", rs, 32'd7);
    chk("sub_rt", rt, 32'd9);

    step(iins(6'h0C, 5'd2, 5'd5, 16'd0), 1, 0, 0, 0, 0, 0);
    step(rins(6'h00, 5'd5, 5'd1, 5'd6), 1, 0, 0, 0, 0, 0);
    chk("loaduse_bubble", 32'(op), 32'h3F);
    step(rins(6'h00, 5'd5, 5'd1, 5'd6), 1, 0, 0, 0, 0, 0);
    chk("loaduse_issue", 32'(op), 32'h00);

    step(iins(6'h0C, 5'd0, 5'd5, 16'd4), 1, 0, 0, 0, 0, 0);
    step(rins(6'h00, 5'd5, 5'd5, 5'd6), 1, 1, 0, 0, 0, 0);
    step(iins(6'h0F, 5'd2, 5'd3, 16'd8), 1, 1, 0, 0, 0, 0);
    step(iins(6'h0D, 5'd2, 5'd3, 16'd8), 1, 0, 0, 0, 0, 0);

    step(rins(6'h06, 5'd7, 5'd0, 5'd8), 1, 0, 1, 5'd7, 32'h1234, 0);
`ifdef ID_WB_BYPASS_EN
    chk("bypass_rs", rs, 32'h1234);
`else
    chk("no_bypass_rs", rs, 32'h0);
`endif

    step(32'h44000000, 1, 0, 0, 0, 0, 0);
    chk("halt_set", 32'(halted), 32'd1);
    for (int k = 0; k < 3; k++) step(rins(6'h00, 5'd1, 5'd2, 5'd3), 1, 0, 0, 0, 0, 0);
    step(iins(6'h0C, 5'd0, 5'd5, 16'd4), 1, 0, 0, 0, 0, 1);
    chk("halt_cleared", 32'(halted), 32'd0);
    step(32'h0401FFFB, 1, 0, 0, 0, 0, 0);
    chk("after_halt_op", 32'(op), 32'h01);

    for (int k = 0; k < 600; k++) begin
      logic [5:0] ro;
      logic [31:0] ri;
      ro = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 16));
      if ($urandom_range(0, 3) == 0) ro = 6'h0C;
      ri = {ro, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      step(ri, $urandom_range(0, 7) != 0, $urandom_range(0, 15) == 0,
           1'($urandom), 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
